// File: rtl/alu_sequencer.sv
// Multi-cycle driver for a 4-bit combinational ALU: streams a NIBBLES-wide operation
// LSB-first through the ALU, chaining carry, then reports result/carry/zero with a done pulse.
module alu_sequencer #(
  parameter int unsigned NIBBLES = 2,
  localparam int unsigned W = 4 * NIBBLES
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start_i,
  input  logic [2:0]   op_i,
  input  logic [W-1:0] opa_i,
  input  logic [W-1:0] opb_i,
  input  logic         cin_init_i,
  output logic         busy_o,
  output logic         done_o,
  output logic         err_o,
  output logic [W-1:0] result_o,
  output logic         carry_o,
  output logic         zero_o,
  output logic [3:0]   alu_a_o,
  output logic [3:0]   alu_b_o,
  output logic [2:0]   alu_sel_o,
  output logic         alu_cin_o,
  input  logic [3:0]   alu_out_i,
  input  logic         alu_cout_i
);

  localparam int unsigned IdxW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [2:0] SelPassA = 3'b111;

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e            state_q, state_d;
  logic [IdxW-1:0]   idx_q, idx_d;
  logic [W-1:0]      a_q, a_d;
  logic [W-1:0]      b_q, b_d;
  logic [2:0]        op_q, op_d;
  logic              carry_q, carry_d;
  logic [W-1:0]      result_q, result_d;
  logic              err_q, err_d;
  logic [3:0]        nib_a, nib_b;
  logic              arith;

  assign arith = ~op_q[2];

  // Constant-index loop avoids width pitfalls of a variable part-select on a narrow idx.
  always_comb begin
    nib_a = 4'h0;
    nib_b = 4'h0;
    for (int unsigned i = 0; i < NIBBLES; i++) begin
      if (idx_q == IdxW'(i)) begin
        nib_a = a_q[4*i +: 4];
        nib_b = b_q[4*i +: 4];
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    a_d       = a_q;
    b_d       = b_q;
    op_d      = op_q;
    carry_d   = carry_q;
    result_d  = result_q;
    err_d     = 1'b0;
    alu_a_o   = 4'h0;
    alu_b_o   = 4'h0;
    alu_sel_o = SelPassA;
    alu_cin_o = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (start_i) begin
          if (op_i[2:1] != 2'b00) begin
            a_d     = opa_i;
            b_d     = opb_i;
            op_d    = op_i;
            idx_d   = '0;
            carry_d = ~op_i[2] & cin_init_i;
            state_d = StRun;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      StRun: begin
        alu_a_o   = nib_a;
        alu_b_o   = nib_b;
        alu_sel_o = op_q;
        alu_cin_o = arith & carry_q;
        for (int unsigned i = 0; i < NIBBLES; i++) begin
          if (idx_q == IdxW'(i)) result_d[4*i +: 4] = alu_out_i;
        end
        carry_d = arith & alu_cout_i;
        idx_d   = idx_q + 1'b1;
        if (idx_q == IdxW'(NIBBLES - 1)) state_d = StDone;
      end
      StDone: begin
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      idx_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      op_q     <= SelPassA;
      carry_q  <= 1'b0;
      result_q <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      a_q      <= a_d;
      b_q      <= b_d;
      op_q     <= op_d;
      carry_q  <= carry_d;
      result_q <= result_d;
      err_q    <= err_d;
    end
  end

  assign busy_o   = (state_q != StIdle);
  assign done_o   = (state_q == StDone);
  assign err_o    = err_q;
  assign result_o = result_q;
  assign carry_o  = carry_q;
  assign zero_o   = (result_q == '0);

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed bench for alu_sequencer (NIBBLES=2) with a behavioural 4-bit ALU attached.
module tb_alu_sequencer;

  localparam int unsigned NIBBLES = 2;
  localparam int unsigned W = 4 * NIBBLES;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [2:0]   op = 3'b000;
  logic [W-1:0] opa = '0;
  logic [W-1:0] opb = '0;
  logic         cin_init = 1'b0;
  logic         busy, done, err, carry, zero;
  logic [W-1:0] result;
  logic [3:0]   alu_a, alu_b, alu_out;
  logic [2:0]   alu_sel;
  logic         alu_cin, alu_cout;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  alu_sequencer #(.NIBBLES(NIBBLES)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start_i    (start),
    .op_i       (op),
    .opa_i      (opa),
    .opb_i      (opb),
    .cin_init_i (cin_init),
    .busy_o     (busy),
    .done_o     (done),
    .err_o      (err),
    .result_o   (result),
    .carry_o    (carry),
    .zero_o     (zero),
    .alu_a_o    (alu_a),
    .alu_b_o    (alu_b),
    .alu_sel_o  (alu_sel),
    .alu_cin_o  (alu_cin),
    .alu_out_i  (alu_out),
    .alu_cout_i (alu_cout)
  );

  // Reference 4-bit ALU; sub is A + ~B + cin so carry=1 means no borrow.
  always_comb begin
    logic [4:0] s;
    s = 5'h00;
    case (alu_sel)
      3'b010: s = {1'b0, alu_a} + {1'b0, ~alu_b} + {4'h0, alu_cin};
      3'b011: s = {1'b0, alu_a} + {1'b0, alu_b} + {4'h0, alu_cin};
      3'b100: s = {1'b0, alu_a ^ alu_b};
      3'b101: s = {1'b0, alu_a | alu_b};
      3'b110: s = {1'b0, alu_a & alu_b};
      3'b111: s = {1'b0, alu_a};
      default: s = 5'h00;
    endcase
    alu_out  = s[3:0];
    alu_cout = s[4];
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Called #1 after a clock edge; start is sampled at the next edge (edge k).
  task automatic run_op(input string tag, input logic [2:0] o, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic ci, input logic [W-1:0] exp_res,
                        input logic exp_carry, input logic exp_cin0, input logic exp_cin1);
    start = 1'b1; op = o; opa = a; opb = b; cin_init = ci;
    @(posedge clk); #1;
    start = 1'b0;
    check_eq({tag, " busy k+1"}, 32'(busy), 32'd1);
    check_eq({tag, " done k+1"}, 32'(done), 32'd0);
    check_eq({tag, " sel k+1"}, 32'(alu_sel), 32'(o));
    check_eq({tag, " cin nib0"}, 32'(alu_cin), 32'(exp_cin0));
    @(posedge clk); #1;
    check_eq({tag, " cin nib1"}, 32'(alu_cin), 32'(exp_cin1));
    check_eq({tag, " done k+2"}, 32'(done), 32'd0);
    @(posedge clk); #1;
    check_eq({tag, " done k+3"}, 32'(done), 32'd1);
    check_eq({tag, " result"}, 32'(result), 32'(exp_res));
    check_eq({tag, " carry"}, 32'(carry), 32'(exp_carry));
    check_eq({tag, " zero"}, 32'(zero), 32'(exp_res == '0));
    check_eq({tag, " sel done"}, 32'(alu_sel), 32'h7);
    @(posedge clk); #1;
    check_eq({tag, " done k+4"}, 32'(done), 32'd0);
    check_eq({tag, " busy k+4"}, 32'(busy), 32'd0);
    check_eq({tag, " result held"}, 32'(result), 32'(exp_res));
  endtask

  initial begin
    int done_cnt;
    int err_cnt;

    repeat (2) @(posedge clk);
    #1;
    check_eq("rst busy", 32'(busy), 32'd0);
    check_eq("rst done", 32'(done), 32'd0);
    check_eq("rst err", 32'(err), 32'd0);
    check_eq("rst result", 32'(result), 32'd0);
    check_eq("rst carry", 32'(carry), 32'd0);
    check_eq("rst zero", 32'(zero), 32'd1);
    check_eq("rst alu_a", 32'(alu_a), 32'd0);
    check_eq("rst alu_b", 32'(alu_b), 32'd0);
    check_eq("rst alu_sel", 32'(alu_sel), 32'h7);
    check_eq("rst alu_cin", 32'(alu_cin), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    run_op("add3c05", 3'b011, 8'h3C, 8'h05, 1'b0, 8'h41, 1'b0, 1'b0, 1'b1);
    run_op("addff01", 3'b011, 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1);
    run_op("sub5020", 3'b010, 8'h50, 8'h20, 1'b1, 8'h30, 1'b1, 1'b1, 1'b1);
    run_op("sub2050", 3'b010, 8'h20, 8'h50, 1'b1, 8'hD0, 1'b0, 1'b1, 1'b1);
    run_op("andf03c", 3'b110, 8'hF0, 8'h3C, 1'b1, 8'h30, 1'b0, 1'b0, 1'b0);
    run_op("passa5", 3'b111, 8'hA5, 8'h5A, 1'b1, 8'hA5, 1'b0, 1'b0, 1'b0);
    run_op("xor", 3'b100, 8'hA5, 8'hFF, 1'b0, 8'h5A, 1'b0, 1'b0, 1'b0);
    run_op("or", 3'b101, 8'h81, 8'h18, 1'b0, 8'h99, 1'b0, 1'b0, 1'b0);

    // Illegal op: err for one cycle only, no state change.
    run_op("pass", 3'b111, 8'hA5, 8'h00, 1'b0, 8'hA5, 1'b0, 1'b0, 1'b0);
    start = 1'b1; op = 3'b001; opa = 8'h11; opb = 8'h22;
    @(posedge clk); #1;
    start = 1'b0;
    check_eq("ill err", 32'(err), 32'd1);
    check_eq("ill busy", 32'(busy), 32'd0);
    check_eq("ill result", 32'(result), 32'hA5);
    @(posedge clk); #1;
    check_eq("ill err clr", 32'(err), 32'd0);
    check_eq("ill busy2", 32'(busy), 32'd0);

    // start held through RUN and DONE must not queue a second op.
    start = 1'b1; op = 3'b011; opa = 8'h11; opb = 8'h22; cin_init = 1'b0;
    done_cnt = 0;
    err_cnt = 0;
    @(posedge clk); #1;
    op = 3'b000;
    for (int i = 0; i < 3; i++) begin
      if (done) done_cnt++;
      if (err) err_cnt++;
      @(posedge clk); #1;
    end
    start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (done) done_cnt++;
      if (err) err_cnt++;
      @(posedge clk); #1;
    end
    check_eq("busy start done cnt", 32'(done_cnt), 32'd1);
    check_eq("busy start err cnt", 32'(err_cnt), 32'd0);
    check_eq("busy start result", 32'(result), 32'h33);
    check_eq("busy start idle", 32'(busy), 32'd0);

    // Reset asserted in the first RUN cycle aborts the op.
    start = 1'b1; op = 3'b011; opa = 8'h77; opb = 8'h11;
    @(posedge clk); #1;
    start = 1'b0;
    rst_n = 1'b0;
    #1;
    check_eq("abort busy", 32'(busy), 32'd0);
    check_eq("abort done", 32'(done), 32'd0);
    check_eq("abort result", 32'(result), 32'd0);
    check_eq("abort carry", 32'(carry), 32'd0);
    check_eq("abort zero", 32'(zero), 32'd1);
    check_eq("abort sel", 32'(alu_sel), 32'h7);
    check_eq("abort alu_a", 32'(alu_a), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    done_cnt = 0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      if (done) done_cnt++;
    end
    check_eq("abort no done", 32'(done_cnt), 32'd0);
    run_op("add1234", 3'b011, 8'h12, 8'h34, 1'b0, 8'h46, 1'b0, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/alu_sequencer.md
# alu_sequencer

Multi-cycle driver for the 4-bit ALU. It accepts a wide operation (NIBBLES × 4 bits), streams it through the ALU one nibble per cycle from LSB to MSB, and feeds carry_out back as carry_in. It collects the result nibbles, then reports result, carry and zero with a one-cycle done pulse. It sits between the instruction/control logic and the ALU, and owns all ALU input ports.

## Interface
- NIBBLES, default 2: operand width in nibbles; legal range 1–8; W = 4·NIBBLES.

- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  request; sampled only in IDLE
- op  in  3  ALU select encoding: 010 sub, 011 add, 100 xor, 101 or, 110 and, 111 pass A; 000/001 illegal
- opa  in  W  operand A, sampled with start
- opb  in  W  operand B, sampled with start
- cin_init  in  1  carry into nibble 0 (arithmetic ops only)
- busy  out  1  high whenever state ≠ IDLE
- done  out  1  one-cycle pulse when result is valid
- err  out  1  one-cycle pulse when start is sampled with an illegal op
- result  out  W  final result; held until the next accepted start
- carry  out  1  carry out of the MSB nibble (sub: 1 = no borrow)
- zero  out  1  result == 0
- alu_a  out  4  to ALU in_A
- alu_b  out  4  to ALU in_B
- alu_sel  out  3  to ALU sel_in
- alu_cin  out  1  to ALU carry_in
- alu_out  in  4  from ALU out
- alu_cout  in  1  from ALU carry_out

## Operation
- States: IDLE, RUN, DONE.
- IDLE, start=1, legal op (op[2:1] ≠ 00):
  - latch opa, opb and op;
  - set idx=0;
  - set carry register = cin_init for arithmetic ops (op[2]=0), 0 for logic/pass ops;
  - go to RUN.
- IDLE, start=1, illegal op: err=1 for one cycle, state stays IDLE, result/carry/zero unchanged.
- RUN, combinational drive to the ALU:
  - alu_a = latched A nibble idx; alu_b = latched B nibble idx;
  - alu_sel = latched op;
  - alu_cin = carry register for arithmetic ops, 0 for logic/pass ops.
- RUN, at each clock edge:
  - result nibble idx ← alu_out;
  - carry register ← alu_cout (forced 0 for logic/pass);
  - idx ← idx+1;
  - when idx = NIBBLES−1, go to DONE.
- DONE: done=1 for exactly one cycle, carry output = carry register, then go to IDLE.
- start while busy: ignored, with no queuing and no err.
- IDLE/DONE ALU drive: alu_a=0, alu_b=0, alu_sel=111, alu_cin=0.
- zero is computed from the registered result. It is valid whenever state = DONE or IDLE and has completed at least one op since reset.
- result nibbles written in RUN are visible on result as they land. Consumers must qualify result with done, or with busy=0.

## Timing
- Reset (rst_n=0, asynchronous):
  - state=IDLE, idx=0;
  - busy=0, done=0, err=0;
  - result=0, carry=0, zero=1;
  - alu_a=0, alu_b=0, alu_sel=111, alu_cin=0.
- start sampled at edge k:
  - busy rises after edge k;
  - RUN occupies cycles k+1 … k+NIBBLES;
  - done is high in cycle k+NIBBLES+1;
  - busy falls after that cycle.
- Throughput: next start is accepted at the edge ending the first IDLE cycle, giving one op per NIBBLES+2 cycles.
- NIBBLES=1: a single RUN cycle, then DONE.
- err is high in cycle k+1 only.
- Reset asserted mid-RUN or in DONE: aborts immediately, no done pulse, all outputs go to reset values. After release, the first start behaves normally.
- ALU is purely combinational: alu_out/alu_cout are sampled in the same cycle alu_* is driven. No ALU pipeline latency is permitted.

## Test plan
- NIBBLES=2, add 0x3C+0x05, cin_init=0 -> done in cycle k+3; result=0x41, carry=0, zero=0. Check that alu_cin on nibble 1 equals nibble-0 carry (1).
- Add 0xFF+0x01, cin_init=0 -> result=0x00, carry=1, zero=1.
- Sub 0x50−0x20, cin_init=1 -> result=0x30, carry=1. Then sub 0x20−0x50 -> result=0xD0, carry=0.
- And 0xF0&0x3C, cin_init=1 -> result=0x30, carry=0. alu_cin stays 0 on both nibbles. Repeat with pass A 0xA5 -> 0xA5.
- op=001 with start -> err pulse one cycle, busy stays 0, result unchanged. start asserted during RUN -> ignored, exactly one done pulse.
- rst_n low in cycle k+1 of an add -> all outputs at reset values, no done. Next add 0x12+0x34 -> result=0x46 after 3 cycles.
